// File: rtl/enc_4_2_rr_seq_pkg.sv
// Shared types and defaults for the sequential 4-to-2 request encoder.
// Imported by the top and the priority-select sub-module.
package enc_4_2_rr_seq_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    localparam int ENC_N = 4;

endpackage

// File: rtl/enc_4_2_rr_seq_prio_sel.sv
// Combinational request selector.
// Selects either the highest set index, or the first set index after ptr in rotating order.
module enc_4_2_rr_seq_prio_sel
    import enc_4_2_rr_seq_pkg::*;
#(
    parameter int N  = ENC_N,
    parameter int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          rr,
    output logic [CW-1:0] idx,
    output logic          any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        if (rr) begin
            // Scan starts one past the last granted line so it ends up at the back of the queue.
            for (int i = 0; i < N; i++) begin
                if (!any && req[(int'(ptr) + 1 + i) % N]) begin
                    any = 1'b1;
                    idx = CW'((int'(ptr) + 1 + i) % N);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (!any && req[i]) begin
                    any = 1'b1;
                    idx = CW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/enc_4_2_rr_seq.sv
// Sequential 4-to-2 encoder: sticky pending requests, one encoded index per valid/ack handshake.
// All outputs are registered; a one-cycle bubble follows every accepted code.
//
// state     | meaning
// S_IDLE    | no code presented; load the next pending request if any
// S_PRESENT | o2 valid and held until the consumer acks
module enc_4_2_rr_seq
    import enc_4_2_rr_seq_pkg::*;
#(
    parameter int N  = ENC_N,
    parameter int RR = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [N-1:0]         i4,
    input  logic                 o_ack,
    output logic [$clog2(N)-1:0] o2,
    output logic                 o_valid,
    output logic [N-1:0]         o_pend
);

    localparam int CW = $clog2(N);

    state_t        state, state_nx;
    logic [N-1:0]  pend, pend_nx;
    logic [CW-1:0] ptr, ptr_nx;
    logic [CW-1:0] o2_nx;
    logic          valid_nx;
    logic [N-1:0]  clr_mask;
    logic [CW-1:0] sel_idx;
    logic          sel_any;

    enc_4_2_rr_seq_prio_sel #(
        .N  (N),
        .CW (CW)
    ) u_sel (
        .req (pend),
        .ptr (ptr),
        .rr  (RR != 0),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pend    <= '0;
            ptr     <= CW'(N - 1);
            o2      <= '0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            ptr     <= ptr_nx;
            o2      <= o2_nx;
            o_valid <= valid_nx;
        end
    end

    always_comb begin
        clr_mask = '0;
        if (o_valid && o_ack)
            clr_mask = N'(1) << o2;
        // OR-ing the new capture after the clear lets a same-cycle request re-pend its line.
        pend_nx  = (pend & ~clr_mask) | (en ? i4 : '0);
        state_nx = state;
        ptr_nx   = ptr;
        o2_nx    = o2;
        valid_nx = o_valid;

        case (state)
            S_IDLE: begin
                if (sel_any) begin
                    o2_nx    = sel_idx;
                    valid_nx = 1'b1;
                    state_nx = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (o_ack) begin
                    valid_nx = 1'b0;
                    state_nx = S_IDLE;
                    if (RR != 0)
                        ptr_nx = o2;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (clr) begin
            pend_nx  = '0;
            valid_nx = 1'b0;
            o2_nx    = o2;
            state_nx = S_IDLE;
        end
    end

    assign o_pend = pend;

endmodule

// File: tb/tb_enc_4_2_rr_seq.sv
// Directed bench for enc_4_2_rr_seq: one fixed-priority and one round-robin instance on shared inputs.
module tb_enc_4_2_rr_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic [3:0] i4;
    logic       o_ack;

    logic [1:0] o2_f, o2_r;
    logic       ov_f, ov_r;
    logic [3:0] op_f, op_r;

    int n_tests = 0;
    int n_fail  = 0;

    enc_4_2_rr_seq #(.N(4), .RR(0)) u_fix (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clr),
        .i4      (i4),
        .o_ack   (o_ack),
        .o2      (o2_f),
        .o_valid (ov_f),
        .o_pend  (op_f)
    );

    enc_4_2_rr_seq #(.N(4), .RR(1)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clr),
        .i4      (i4),
        .o_ack   (o_ack),
        .o2      (o2_r),
        .o_valid (ov_r),
        .o_pend  (op_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_rr_a [4] = '{0, 1, 2, 3};
    int exp_rr_b [2] = '{0, 3};
    int exp_fx_a [2] = '{3, 1};

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        i4      = 4'b0000;
        o_ack   = 1'b0;
        #12;
        chk("rst_valid", 32'(ov_r), 0);
        chk("rst_o2",    32'(o2_r), 0);
        chk("rst_pend",  32'(op_r), 0);
        reset_n = 1'b1;

        // Idle after reset release.
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_valid", 32'(ov_r), 0);
            chk("idle_o2",    32'(o2_r), 0);
            chk("idle_pend",  32'(op_f), 0);
        end

        // Fixed priority drains 1010 as 3 then 1, two cycles apart.
        en = 1'b1; o_ack = 1'b1; i4 = 4'b1010;
        tick();
        i4 = 4'b0000;
        chk("fx_pend_cap", 32'(op_f), 32'hA);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("fx_valid", 32'(ov_f), 1);
            chk("fx_code",  32'(o2_f), 32'(exp_fx_a[k]));
            tick();
            chk("fx_bubble", 32'(ov_f), 0);
        end
        chk("fx_pend_empty", 32'(op_f), 0);
        chk("rr_drained",    32'(op_r), 0);

        // Round-robin: 1111 gives 0,1,2,3.
        i4 = 4'b1111;
        tick();
        i4 = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_valid", 32'(ov_r), 1);
            chk("rr_code",  32'(o2_r), 32'(exp_rr_a[k]));
            tick();
            chk("rr_bubble", 32'(ov_r), 0);
        end
        // Pointer sits at 3, so 1001 wraps to 0 first.
        i4 = 4'b1001;
        tick();
        i4 = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rr2_code", 32'(o2_r), 32'(exp_rr_b[k]));
            tick();
        end
        chk("rr2_pend_empty", 32'(op_r), 0);

        // Backpressure holds code 2.
        o_ack = 1'b0; i4 = 4'b0100;
        tick();
        i4 = 4'b0000;
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("bp_valid", 32'(ov_r), 1);
            chk("bp_code",  32'(o2_r), 2);
        end
        o_ack = 1'b1;
        tick();
        chk("bp_release", 32'(ov_r), 0);
        chk("bp_pend",    32'(op_r), 0);

        // en=0 leaves pending untouched while a code waits.
        o_ack = 1'b0; i4 = 4'b0001;
        tick();
        tick();
        chk("en0_pre_code", 32'(o2_r), 0);
        en = 1'b0; i4 = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("en0_pend", 32'(op_r), 32'h1);
        end
        i4 = 4'b0000; o_ack = 1'b1;
        tick();
        chk("en0_drain", 32'(op_r), 0);

        // Set wins over ack-clear on the same line.
        en = 1'b1; o_ack = 1'b0; i4 = 4'b0100;
        tick();
        i4 = 4'b0000;
        tick();
        chk("col_code", 32'(o2_r), 2);
        o_ack = 1'b1; i4 = 4'b0100;
        tick();
        i4 = 4'b0000;
        chk("col_repend", 32'(op_r), 32'h4);
        chk("col_bubble", 32'(ov_r), 0);
        tick();
        chk("col_revalid", 32'(ov_r), 1);
        chk("col_recode",  32'(o2_r), 2);
        tick();
        chk("col_done", 32'(op_r), 0);

        // Async reset mid-handshake.
        o_ack = 1'b0; i4 = 4'b1000;
        tick();
        i4 = 4'b0000;
        tick();
        chk("mid_valid", 32'(ov_r), 1);
        chk("mid_code",  32'(o2_r), 3);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov_r), 0);
        chk("arst_o2",    32'(o2_r), 0);
        chk("arst_pend",  32'(op_r), 0);
        #2 reset_n = 1'b1;

        // Synchronous flush overrides the pending load.
        i4 = 4'b1100;
        tick();
        i4 = 4'b0000;
        chk("clr_pre_pend", 32'(op_r), 32'hC);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_pend",  32'(op_r), 0);
        chk("clr_valid", 32'(ov_r), 0);
        tick();
        chk("clr_stay_idle", 32'(ov_r), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
